// File: rtl/jt10_adpcma_pkg.sv
// Shared constants, slot record and arithmetic helpers for the ADPCM-A decoder.
package jt10_adpcma_pkg;

    localparam int ADPCMA_IDX_MAX = 48;

    localparam logic [10:0] STEP_TBL [0:48] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [4:0] IDX_ADJ [0:7] = '{
        -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd5, 5'sd7, 5'sd9
    };

    // One channel's worth of pipeline content in the early stages
    typedef struct packed {
        logic [5:0]  ch;
        logic [3:0]  nib;
        logic        decon;
        logic        clr;
        logic [11:0] acc;
        logic [5:0]  idx;
    } slot_t;

    // ((2*m+1)*step)>>3 built from shifted copies of step; peaks at 2910
    function automatic logic [11:0] adpcma_diff(input logic [10:0] step, input logic [2:0] m);
        logic [14:0] p;
        p = {4'b0, step};
        if (m[0]) p = p + {3'b0, step, 1'b0};
        if (m[1]) p = p + {2'b0, step, 2'b0};
        if (m[2]) p = p + {1'b0, step, 3'b0};
        return 12'(p >> 3);
    endfunction

    // Step index update, widened to 7-bit signed so -1 and >48 can be clamped
    function automatic logic [5:0] adpcma_idx_next(input logic [5:0] idx, input logic [2:0] m);
        logic signed [6:0] t;
        logic signed [4:0] adj;
        adj = IDX_ADJ[m];
        t   = $signed({1'b0, idx}) + $signed({{2{adj[4]}}, adj});
        if (t < 7'sd0)
            return 6'd0;
        else if (t > 7'(ADPCMA_IDX_MAX))
            return 6'(ADPCMA_IDX_MAX);
        else
            return t[5:0];
    endfunction

endpackage

// File: rtl/jt10_adpcma_steptbl.sv
// Registered step-size lookup: forms the second pipeline stage.
module jt10_adpcma_steptbl
    import jt10_adpcma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [5:0]  idx,
    output logic [10:0] step
);

    // Out-of-range indices cannot occur from the decoder but map to the top entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step <= '0;
        else if (cen)
            step <= (idx > 6'(ADPCMA_IDX_MAX)) ? STEP_TBL[ADPCMA_IDX_MAX] : STEP_TBL[idx];
    end

endmodule

// File: rtl/jt10_adpcma_dec.sv
// Six-channel time-multiplexed ADPCM-A decoder. Channel state circulates
// through a six-stage pipeline, so each channel's acc/idx leaves the last
// stage exactly when that channel is presented again on the inputs.
module jt10_adpcma_dec
    import jt10_adpcma_pkg::*;
(
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic [5:0]  cur_ch,
    input  logic [7:0]  rom_data,
    input  logic        sel,
    input  logic        decon,
    input  logic        clr,
    output logic [11:0] pcm,
    output logic [5:0]  pcm_ch
);

    slot_t       s1, s2, s3;
    logic [10:0] step2;
    logic [11:0] diff3;

    logic [5:0]  ch4;
    logic [2:0]  m4;
    logic        upd4;
    logic [11:0] acc4;
    logic [5:0]  idx4;

    logic [5:0]  ch5;
    logic [11:0] acc5;
    logic [5:0]  idx5;

    logic [11:0] acc6;
    logic [5:0]  idx6;

    logic [3:0]  nib_in;

    assign nib_in = sel ? rom_data[3:0] : rom_data[7:4];

    // P1: sample inputs and pick up the circulating state; clr zeroes it here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (cen) begin
            s1.ch    <= cur_ch;
            s1.nib   <= nib_in;
            s1.decon <= decon;
            s1.clr   <= clr;
            s1.acc   <= clr ? 12'd0 : acc6;
            s1.idx   <= clr ? 6'd0  : idx6;
        end
    end

    // P2: step lookup runs alongside the slot copy
    jt10_adpcma_steptbl u_steptbl (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .idx   (s1.idx),
        .step  (step2)
    );

    // P2 slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s2 <= '0;
        else if (cen)
            s2 <= s1;
    end

    // P3: magnitude of the accumulator change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3    <= '0;
            diff3 <= '0;
        end else if (cen) begin
            s3    <= s2;
            diff3 <= adpcma_diff(step2, s2.nib[2:0]);
        end
    end

    // P4: accumulate with 12-bit two's-complement wrap; clr/decon=0 slots hold acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch4  <= '0;
            m4   <= '0;
            upd4 <= 1'b0;
            acc4 <= '0;
            idx4 <= '0;
        end else if (cen) begin
            ch4  <= s3.ch;
            m4   <= s3.nib[2:0];
            upd4 <= s3.decon && !s3.clr;
            idx4 <= s3.idx;
            if (s3.decon && !s3.clr)
                acc4 <= s3.nib[3] ? (s3.acc - diff3) : (s3.acc + diff3);
            else
                acc4 <= s3.acc;
        end
    end

    // P5: step index adaptation with clamping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch5  <= '0;
            acc5 <= '0;
            idx5 <= '0;
        end else if (cen) begin
            ch5  <= ch4;
            acc5 <= acc4;
            idx5 <= upd4 ? adpcma_idx_next(idx4, m4) : idx4;
        end
    end

    // P6: commit state for recirculation and publish the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc6   <= '0;
            idx6   <= '0;
            pcm    <= '0;
            pcm_ch <= 6'b000001;
        end else if (cen) begin
            acc6   <= acc5;
            idx6   <= idx5;
            pcm    <= acc5;
            pcm_ch <= ch5;
        end
    end

endmodule

// File: tb/tb_jt10_adpcma_dec.sv
// Self-checking bench for jt10_adpcma_dec: directed vector table, hand
// sequences for saturation/interleave/reset, and randomized slots checked
// against a per-slot arithmetic reference model.
module tb_jt10_adpcma_dec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic [5:0]  cur_ch = '0;
    logic [7:0]  rom_data = '0;
    logic        sel = 1'b0;
    logic        decon = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] pcm;
    logic [5:0]  pcm_ch;

    always #5 clk = ~clk;

    jt10_adpcma_dec dut (
        .rst_n    (rst_n),
        .clk      (clk),
        .cen      (cen),
        .cur_ch   (cur_ch),
        .rom_data (rom_data),
        .sel      (sel),
        .decon    (decon),
        .clr      (clr),
        .pcm      (pcm),
        .pcm_ch   (pcm_ch)
    );

    int checks = 0;
    int errors = 0;

    int step_tbl [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                          107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,
                          449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};
    int idx_adj [8] = '{-1,-1,-1,-1,2,5,7,9};

    // Reference state, indexed by rotation slot (cen count mod 6)
    int m_acc [6];
    int m_idx [6];
    int k;
    int q_pcm [$];
    int q_ch  [$];

    typedef struct {
        logic [7:0]  d;
        logic        s;
        logic        dc;
        logic        cl;
        logic [11:0] exp;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [5:0] oh(input int i);
        logic [5:0] one;
        one = 6'b000001;
        return one << i;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_acc[i] = 0;
            m_idx[i] = 0;
        end
        k = 0;
        q_pcm.delete();
        q_ch.delete();
    endtask

    // One cen slot: drive, clock, update model, compare the sample due now
    task automatic do_cen(input logic [5:0] tag, input logic [7:0] d, input logic s,
                          input logic dc, input logic cl, input int idle);
        int slot, nib, m, dd, a, ep, ec;
        @(negedge clk);
        cur_ch = tag; rom_data = d; sel = s; decon = dc; clr = cl; cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
        slot = k % 6;
        nib  = s ? int'(d[3:0]) : int'(d[7:4]);
        if (cl) begin
            m_acc[slot] = 0;
            m_idx[slot] = 0;
        end else if (dc) begin
            m  = nib % 8;
            dd = ((2 * m + 1) * step_tbl[m_idx[slot]]) / 8;
            a  = (nib >= 8) ? m_acc[slot] - dd : m_acc[slot] + dd;
            m_acc[slot] = a & 4095;
            m_idx[slot] = m_idx[slot] + idx_adj[m];
            if (m_idx[slot] < 0)  m_idx[slot] = 0;
            if (m_idx[slot] > 48) m_idx[slot] = 48;
        end
        q_pcm.push_back(m_acc[slot]);
        q_ch.push_back(int'(tag));
        k++;
        if (q_pcm.size() == 6) begin
            ep = q_pcm.pop_front();
            ec = q_ch.pop_front();
            chk("model_pcm", int'(pcm), ep);
            chk("model_pcm_ch", int'(pcm_ch), ec);
        end
        repeat (idle) @(posedge clk);
    endtask

    task automatic slot_std(input logic [7:0] d, input logic s, input logic dc, input logic cl);
        do_cen(oh(k % 6), d, s, dc, cl, int'($urandom_range(0, 2)));
    endtask

    task automatic idle_slot();
        slot_std(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Present one ch0 slot and return its output five cens later
    task automatic ch0_rec(input logic [7:0] d, input logic s, input logic dc, input logic cl,
                           output logic [11:0] res, output logic [5:0] rch);
        while (k % 6 != 0) idle_slot();
        slot_std(d, s, dc, cl);
        repeat (5) idle_slot();
        res = pcm;
        rch = pcm_ch;
    endtask

    initial begin
        logic [11:0] r, pa, pb;
        logic [5:0]  rc;
        int          exp0, rr;
        logic [5:0]  tag;

        vt[0]  = '{8'h00, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 12'h002};
        vt[2]  = '{8'h00, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[3]  = '{8'h70, 1'b0, 1'b1, 1'b0, 12'h01E};
        vt[4]  = '{8'hF0, 1'b1, 1'b1, 1'b0, 12'h022};
        vt[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[6]  = '{8'h80, 1'b0, 1'b1, 1'b0, 12'hFFE};
        vt[7]  = '{8'h08, 1'b0, 1'b1, 1'b0, 12'h000};
        vt[8]  = '{8'h77, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[9]  = '{8'h1F, 1'b1, 1'b1, 1'b0, 12'hFE2};
        vt[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 12'hFE2};
        vt[11] = '{8'h01, 1'b1, 1'b1, 1'b0, 12'hFEF};

        model_reset();
        #12;
        chk("reset_pcm", int'(pcm), 0);
        chk("reset_pcm_ch", int'(pcm_ch), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            ch0_rec(vt[i].d, vt[i].s, vt[i].dc, vt[i].cl, r, rc);
            chk($sformatf("vec%0d_pcm", i), int'(r), int'(vt[i].exp));
            chk($sformatf("vec%0d_pcm_ch", i), int'(rc), 1);
        end

        // Index saturation and accumulator wrap with the largest step
        ch0_rec(8'h00, 1'b0, 1'b0, 1'b1, r, rc);
        for (int i = 0; i < 20; i++) ch0_rec(8'h70, 1'b0, 1'b1, 1'b0, r, rc);
        ch0_rec(8'h70, 1'b0, 1'b1, 1'b0, pa, rc);
        ch0_rec(8'h70, 1'b0, 1'b1, 1'b0, pb, rc);
        chk("sat_wrap_delta", int'((pb - pa) & 12'hFFF), 12'hB5E);

        // Interleave: ch1 decodes from the low nibble while ch2 holds
        exp0 = m_acc[0];
        idle_slot();
        slot_std(8'h07, 1'b1, 1'b1, 1'b0);
        slot_std(8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (3) idle_slot();
        chk("ilv_ch0_pcm", int'(pcm), exp0);
        chk("ilv_ch0_tag", int'(pcm_ch), 1);
        idle_slot();
        chk("ilv_ch1_pcm", int'(pcm), 30);
        chk("ilv_ch1_tag", int'(pcm_ch), 2);
        idle_slot();
        chk("ilv_ch2_pcm", int'(pcm), 0);
        chk("ilv_ch2_tag", int'(pcm_ch), 4);

        // Randomized slots, including invalid tags and cen gaps, with one mid-stream reset
        for (int i = 0; i < 700; i++) begin
            if (i == 350) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("midrst_pcm", int'(pcm), 0);
                chk("midrst_pcm_ch", int'(pcm_ch), 1);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                ch0_rec(8'h00, 1'b0, 1'b1, 1'b0, r, rc);
                chk("postrst_pcm", int'(r), 2);
                chk("postrst_pcm_ch", int'(rc), 1);
            end
            rr = int'($urandom_range(0, 39));
            if (rr == 0)      tag = 6'b000011;
            else if (rr == 1) tag = 6'b000000;
            else              tag = oh(k % 6);
            do_cen(tag, 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                   int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt10_adpcma_dec.md
Name: jt10_adpcma_dec

Overview:
- Six-channel, time-multiplexed ADPCM-A decoder. Sits directly downstream of the ADPCM-A address counter.
- Consumes the counter's stage-1 outputs (sel, decon, clr) plus the ROM byte fetched at that address. Produces one 12-bit signed PCM sample per channel slot.
- Per-channel state (accumulator and step index) lives in a 6-deep rotating pipeline, so no RAM is needed.
- Output feeds the ADPCM-A channel mixer/attenuator.

Parameters:
- none; channel count (6) and widths are fixed by the chip.

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  CPU clock
- cen  in  1  666 kHz clock enable; all state advances only on clk edges with cen=1
- cur_ch  in  6  one-hot channel currently presented on the inputs
- rom_data  in  8  ROM byte for the current channel's address
- sel  in  1  nibble select: 0 = rom_data[7:4], 1 = rom_data[3:0]
- decon  in  1  decode enable: 1 = consume one nibble this slot
- clr  in  1  start of a new section: reset the channel state
- pcm  out  12  signed decoded sample of channel pcm_ch
- pcm_ch  out  6  one-hot channel that pcm belongs to

Behaviour:
- Reset (async, rst_n=0):
  - all six channel states: acc=0, idx=0
  - pcm=0, pcm_ch=6'b000001
  - all pipeline registers cleared
- Sampling:
  - cur_ch, rom_data, sel, decon and clr are sampled together on the same cen edge.
  - The upstream counter registers these, and the ROM is read within that cen period.
- Pipeline: six stages P1..P6, one channel per stage, rotating each cen. Channel state leaving P6 re-enters P1, aligned with that channel's next presentation on cur_ch (6-cen period).
  - P1: latch nibble n = sel ? rom_data[3:0] : rom_data[7:4]; also latch decon, clr, cur_ch.
  - P2: step = STEP_TBL[idx] (11-bit unsigned, 49 entries).
  - P3: diff = ((2*n[2:0]+1)*step)>>3, computed by shift-add (no multiplier). Maximum 2910, fits 12-bit unsigned.
  - P4: sum = n[3] ? acc-diff : acc+diff in 13 bits; the new acc is sum[11:0], i.e. two's-complement wrap, no saturation.
  - P5: idx_new = idx + IDX_ADJ[n[2:0]], with IDX_ADJ = {-1,-1,-1,-1,+2,+5,+7,+9}. Clamp to 0..48; compute in 7-bit signed before clamping.
  - P6: commit; pcm <= committed acc; pcm_ch <= the channel's one-hot.
- Latency: pcm updates 5 cen after the P1 sample of that channel. pcm and pcm_ch change every cen and hold between cens.
- Control precedence, evaluated per slot:
  - clr=1: acc=0 and idx=0, regardless of decon. The nibble is discarded and pcm for that slot is 0.
  - clr=0, decon=0: acc and idx unchanged; pcm repeats the stored acc.
  - clr=0, decon=1: normal decode.
- Invalid cur_ch (not one-hot, or zero): the slot still rotates. Decode follows decon/clr as sampled; the channel tag carried is the sampled value.
- cen=0 for any number of clk cycles: all state frozen.
- Reset mid-stream: all channels return to acc=0, idx=0 immediately. The first cen after release behaves as power-up.

Decomposition:
- Shared package jt10_adpcma_pkg:
  - STEP_TBL constant (16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552)
  - IDX_ADJ constant
  - ADPCMA_IDX_MAX=48
- One sub-module: jt10_adpcma_steptbl, a registered 6-bit-in / 11-bit-out lookup (the P2 stage).

Test Plan:
- Reset, then ch0 with clr=1, then decon=1, sel=0, rom_data=8'h00 → 5 cen later pcm=2 (step 16, diff 2), pcm_ch=000001; stored idx=0 (clamped from -1).
- ch0: clr, then nibble 7 → pcm=30, idx=9; next nibble 0 → diff=37>>3=4, pcm=34, idx=8.
- ch0: clr, then nibble 8 (sign, m=0) → pcm=-2 (12'hFFE), idx stays 0.
- ch0: 20 nibbles of 7 → idx saturates at 48; one further 7 with acc=0 gives 0+2910, wrapping to pcm=-1186; idx remains 48.
- Interleave: ch1 is fed nibble 7 from rom_data=8'h07 with sel=1, while ch2 has decon=0. Required: ch1 pcm=30; ch2 pcm unchanged; ch0 state unaffected.
- clr and decon=1 in the same slot → pcm=0, acc/idx zero. Assert rst_n low mid-stream → pcm=0, pcm_ch=000001 asynchronously.
